// File: rtl/unstripe_lane_ctrl_if.sv
// ---------------------------------------------------------------------------
// unstripe_lane_ctrl_if
// Bundles the two striped receive lanes and the un-striped output side of
// unstripe_lane_ctrl.
//   lane_0/valid_0, lane_1/valid_1 : per-lane receive bytes and qualifiers
//   data_out/valid_out            : rebuilt byte stream
//   aligned, sel                  : alignment status, next lane to pop
//   err_skew, err_ovf             : sticky error flags
// master : the side that drives the lanes and observes the results
// slave  : the controller itself
// ---------------------------------------------------------------------------
interface unstripe_lane_ctrl_if;
  logic [7:0] lane_0;
  logic       valid_0;
  logic [7:0] lane_1;
  logic       valid_1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       aligned;
  logic       sel;
  logic       err_skew;
  logic       err_ovf;

  modport master (
    output lane_0, valid_0, lane_1, valid_1,
    input  data_out, valid_out, aligned, sel, err_skew, err_ovf
  );

  modport slave (
    input  lane_0, valid_0, lane_1, valid_1,
    output data_out, valid_out, aligned, sel, err_skew, err_ovf
  );
endinterface

// File: rtl/unstripe_lane_ctrl.sv
// ---------------------------------------------------------------------------
// unstripe_lane_ctrl
// Two-lane receive controller. Hunts for the COM marker on each lane, buffers
// each locked lane in a small FIFO, tolerates up to MAX_SKEW cycles between
// the two lane locks, then pops the lanes alternately (lane 0 first) to
// rebuild the original byte stream.
// Ports:
//   clk_2f : sole clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : unstripe_lane_ctrl_if.slave (lane inputs, un-striped outputs,
//            aligned / sel status, sticky err_skew / err_ovf)
// ---------------------------------------------------------------------------
module unstripe_lane_ctrl #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [7:0]  COM      = 8'hBC,
  parameter int unsigned MAX_SKEW = 3
) (
  input logic                 clk_2f,
  input logic                 reset,
  unstripe_lane_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (MAX_SKEW > 1) ? $clog2(MAX_SKEW) : 1;
  localparam logic [SW-1:0] SKEW_LAST = SW'(MAX_SKEW - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DESKEW = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      lock_q, lock_d;
  logic [SW-1:0]   skew_q, skew_d;

  logic [7:0]      lane_data [2];
  logic [1:0]      lane_valid;
  logic [1:0]      is_com, wr_en, pop, empty, full;
  logic            ovf, skew_err, flush;

  logic [7:0]      mem_q    [2][DEPTH];
  logic [AW-1:0]   wr_ptr_q [2];
  logic [AW-1:0]   rd_ptr_q [2];
  logic [CW-1:0]   cnt_q    [2];

  logic [7:0]      data_out_q;
  logic            valid_out_q, sel_q, err_skew_q, err_ovf_q;

  assign lane_data[0] = bus.lane_0;
  assign lane_data[1] = bus.lane_1;
  assign lane_valid   = {bus.valid_1, bus.valid_0};

  // Per-lane write / pop qualification. A write is only accepted on a locked
  // lane and never for a COM byte; a pop only ever targets the lane at sel.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a variable unassigned (which would infer a latch).
    is_com = '0;
    wr_en  = '0;
    empty  = '0;
    full   = '0;
    pop    = '0;
    for (int i = 0; i < 2; i++) begin
      is_com[i] = lane_valid[i] && (lane_data[i] == COM);
      wr_en[i]  = lane_valid[i] && (lane_data[i] != COM) && lock_q[i];
      empty[i]  = (cnt_q[i] == '0);
      full[i]   = (cnt_q[i] == CW'(DEPTH));
    end
    if ((state_q == RUN) && !empty[sel_q]) pop[sel_q] = 1'b1;
    // A pop in the same cycle frees the slot, so full+write+pop is legal.
    ovf = |(wr_en & full & ~pop);
  end

  // Alignment state machine.
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    skew_d   = skew_q;
    skew_err = 1'b0;
    flush    = 1'b0;
    case (state_q)
      HUNT: begin
        lock_d = is_com;
        skew_d = '0;
        if (&is_com)      state_d = RUN;
        else if (|is_com) state_d = DESKEW;
      end
      DESKEW: begin
        if (|(is_com & ~lock_q)) begin
          lock_d  = 2'b11;
          state_d = RUN;
        end else if (skew_q == SKEW_LAST) begin
          // This cycle would bring the wait to MAX_SKEW: give up and re-hunt.
          skew_err = 1'b1;
          flush    = 1'b1;
        end else begin
          skew_d = skew_q + SW'(1);
        end
      end
      RUN: ;
      default: state_d = HUNT;
    endcase
    if (ovf) flush = 1'b1;
    if (flush) begin
      state_d = HUNT;
      lock_d  = '0;
      skew_d  = '0;
    end
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state_q    <= HUNT;
      lock_q     <= '0;
      skew_q     <= '0;
      err_skew_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      skew_q     <= skew_d;
      err_skew_q <= err_skew_q | skew_err;
      err_ovf_q  <= err_ovf_q | ovf;
    end
  end

  // FIFO bookkeeping: pointers and occupancy are reset/flushed, storage is not.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
        if (pop[i])   rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
        cnt_q[i] <= cnt_q[i] + CW'(wr_en[i]) - CW'(pop[i]);
      end
    end
  end

  // NOTE: FIFO storage has no reset; the occupancy counter guarantees a slot
  // is only read after it has been written, so clearing it buys nothing.
  always_ff @(posedge clk_2f) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i] && !flush) mem_q[i][wr_ptr_q[i]] <= lane_data[i];
    end
  end

  // Registered output stage.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      sel_q       <= 1'b0;
    end else if (flush) begin
      valid_out_q <= 1'b0;
      sel_q       <= 1'b0;
    end else if (|pop) begin
      data_out_q  <= mem_q[sel_q][rd_ptr_q[sel_q]];
      valid_out_q <= 1'b1;
      sel_q       <= ~sel_q;
    end else begin
      valid_out_q <= 1'b0;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.aligned   = (state_q == RUN);
  assign bus.sel       = sel_q;
  assign bus.err_skew  = err_skew_q;
  assign bus.err_ovf   = err_ovf_q;

endmodule
